// File: rtl/linear_layer_fifo_pkg.sv
// Shared types, constants and helpers for the Linear_Layer SRL FIFO controller and its storage.
package linear_layer_fifo_pkg;

  typedef int unsigned fifo_count_t;

  localparam int unsigned FIFO_ERR_OVF = 0;
  localparam int unsigned FIFO_ERR_UDF = 1;
  localparam int unsigned FIFO_ERR_W   = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/linear_layer_srl_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for the Linear_Layer SRL FIFO.
interface linear_layer_srl_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 1
);
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;

  modport master (
    output if_write, if_din, if_read,
    input  if_full_n, if_dout, if_empty_n
  );

  modport slave (
    input  if_write, if_din, if_read,
    output if_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/linear_layer_srl_storage.sv
// Non-reset shift-register storage: new data enters tap 0, read tap chosen by addr.
module linear_layer_srl_storage
  import linear_layer_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter fifo_count_t DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int unsigned TAP_W = clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_sr [DEPTH];
  logic [TAP_W-1:0]      w_tap;

  always_ff @(posedge clk) begin
    if (we) begin
      r_sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign w_tap = addr[TAP_W-1:0];
  assign dout  = r_sr[w_tap];
endmodule

// File: rtl/linear_layer_srl_fifo_ctrl.sv
// SRL FIFO controller: occupancy count, registered full_n/empty_n flags and sticky error flags.
module linear_layer_srl_fifo_ctrl
  import linear_layer_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter fifo_count_t DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  linear_layer_srl_fifo_ctrl_if.slave fifo,
  output logic [ADDR_WIDTH:0]         count,
  output logic                        err_ovf,
  output logic                        err_udf
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]     r_count;
  logic                    r_full_n;
  logic                    r_empty_n;
  logic [FIFO_ERR_W-1:0]   r_err;

  logic                    w_push;
  logic                    w_pop;
  logic [ADDR_WIDTH:0]     w_count_next;
  logic [ADDR_WIDTH:0]     w_count_m1;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_dout;

  assign w_push     = fifo.if_write & r_full_n;
  assign w_pop      = fifo.if_read  & r_empty_n;
  assign w_count_m1 = r_count - 1'b1;
  assign w_addr     = (r_count == '0) ? '0 : w_count_m1[ADDR_WIDTH-1:0];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = w_count_m1;
    end
  end

  // Flags come from next-count so they track occupancy with exactly one cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
      r_err     <= '0;
    end else begin
      r_count   <= w_count_next;
      r_full_n  <= (w_count_next != DEPTH_C);
      r_empty_n <= (w_count_next != '0);
      if (fifo.if_write && !r_full_n) begin
        r_err[FIFO_ERR_OVF] <= 1'b1;
      end
      if (fifo.if_read && !r_empty_n) begin
        r_err[FIFO_ERR_UDF] <= 1'b1;
      end
    end
  end

  linear_layer_srl_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (w_push),
    .addr (w_addr),
    .din  (fifo.if_din),
    .dout (w_dout)
  );

  assign fifo.if_full_n  = r_full_n;
  assign fifo.if_empty_n = r_empty_n;
  assign fifo.if_dout    = w_dout;
  assign count           = r_count;
  assign err_ovf         = r_err[FIFO_ERR_OVF];
  assign err_udf         = r_err[FIFO_ERR_UDF];
endmodule

// File: tb/tb_linear_layer_srl_fifo_ctrl.sv
// Directed bench for the SRL FIFO controller with a queue-based reference model.
module tb_linear_layer_srl_fifo_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic [AW:0]   count;
  logic          err_ovf;
  logic          err_udf;

  int n_chk;
  int n_fail;

  linear_layer_srl_fifo_ctrl_if #(.DATA_WIDTH(DW)) fifo_if ();

  linear_layer_srl_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fifo    (fifo_if.slave),
    .count   (count),
    .err_ovf (err_ovf),
    .err_udf (err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue, flags recomputed from its size after every edge.
  logic [DW-1:0] m_q[$];
  logic          m_full_n;
  logic          m_empty_n;
  logic          m_ovf;
  logic          m_udf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_full_n  = 1'b1;
      m_empty_n = 1'b0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
    end else begin
      bit acc_push;
      bit acc_pop;
      acc_push = fifo_if.if_write && m_full_n;
      acc_pop  = fifo_if.if_read  && m_empty_n;
      if (fifo_if.if_write && !m_full_n) m_ovf = 1'b1;
      if (fifo_if.if_read && !m_empty_n) m_udf = 1'b1;
      if (acc_pop)  void'(m_q.pop_front());
      if (acc_push) m_q.push_back(fifo_if.if_din);
      m_empty_n = (m_q.size() != 0);
      m_full_n  = (m_q.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("mdl_count",   32'(count),              32'(m_q.size()));
      chk("mdl_empty_n", 32'(fifo_if.if_empty_n), 32'(m_empty_n));
      chk("mdl_full_n",  32'(fifo_if.if_full_n),  32'(m_full_n));
      chk("mdl_err_ovf", 32'(err_ovf),            32'(m_ovf));
      chk("mdl_err_udf", 32'(err_udf),            32'(m_udf));
      if (m_empty_n) chk("mdl_dout", 32'(fifo_if.if_dout), 32'(m_q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [DW-1:0] v);
    fifo_if.if_write = 1'b1;
    fifo_if.if_din   = v;
    step();
    fifo_if.if_write = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [DW-1:0] v);
    fifo_if.if_read = 1'b1;
    #1;
    chk(name, 32'(fifo_if.if_dout), 32'(v));
    step();
    fifo_if.if_read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] s1 [4];
    s1[0] = 8'h11; s1[1] = 8'h22; s1[2] = 8'h33; s1[3] = 8'h44;
    n_chk  = 0;
    n_fail = 0;
    reset_n          = 1'b0;
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b0;
    fifo_if.if_din   = '0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("rst_count",   32'(count),              32'd0);
    chk("rst_empty_n", 32'(fifo_if.if_empty_n), 32'd0);
    chk("rst_full_n",  32'(fifo_if.if_full_n),  32'd1);
    chk("rst_errs",    32'({err_ovf, err_udf}), 32'd0);

    // 1: fill with 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      push1(s1[i]);
      if (i == 0) begin
        chk("s1_empty_n_lat", 32'(fifo_if.if_empty_n), 32'd1);
        chk("s1_head",        32'(fifo_if.if_dout),    32'h11);
      end
    end
    chk("s1_count_full", 32'(count),             32'd4);
    chk("s1_full_n",     32'(fifo_if.if_full_n), 32'd0);

    // 2: writes while full are dropped
    fifo_if.if_write = 1'b1;
    fifo_if.if_din   = 8'h55;
    repeat (3) step();
    fifo_if.if_write = 1'b0;
    chk("s2_count",   32'(count),   32'd4);
    chk("s2_err_ovf", 32'(err_ovf), 32'd1);
    chk("s2_err_udf", 32'(err_udf), 32'd0);
    for (int i = 0; i < 4; i++) pop_expect("s1s2_pop", s1[i]);
    chk("s1_drained_empty_n", 32'(fifo_if.if_empty_n), 32'd0);
    chk("s1_drained_count",   32'(count),              32'd0);

    // 3: reads while empty
    fifo_if.if_read = 1'b1;
    repeat (2) step();
    fifo_if.if_read = 1'b0;
    chk("s3_count",   32'(count),              32'd0);
    chk("s3_empty_n", 32'(fifo_if.if_empty_n), 32'd0);
    chk("s3_err_udf", 32'(err_udf),            32'd1);

    // 4: simultaneous push/pop at count=2
    push1(8'hA0);
    push1(8'hA1);
    fifo_if.if_write = 1'b1;
    fifo_if.if_din   = 8'hA2;
    fifo_if.if_read  = 1'b1;
    #1 chk("s4_head_before", 32'(fifo_if.if_dout), 32'hA0);
    step();
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b0;
    chk("s4_count",      32'(count),            32'd2);
    chk("s4_head_after", 32'(fifo_if.if_dout),  32'hA1);
    pop_expect("s4_pop_a1", 8'hA1);
    pop_expect("s4_pop_a2", 8'hA2);
    chk("s4_empty", 32'(fifo_if.if_empty_n), 32'd0);

    // 5: write+read while full -> pop only
    push1(8'hB0);
    push1(8'hB1);
    push1(8'hB2);
    push1(8'hB3);
    chk("s5_full_n_pre", 32'(fifo_if.if_full_n), 32'd0);
    fifo_if.if_write = 1'b1;
    fifo_if.if_read  = 1'b1;
    fifo_if.if_din   = 8'hCC;
    step();
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b0;
    chk("s5_count",   32'(count),             32'd3);
    chk("s5_err_ovf", 32'(err_ovf),           32'd1);
    chk("s5_full_n",  32'(fifo_if.if_full_n), 32'd1);
    chk("s5_head",    32'(fifo_if.if_dout),   32'hB1);

    // 6: asynchronous reset mid-cycle with count=3
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("s6_count",   32'(count),              32'd0);
    chk("s6_empty_n", 32'(fifo_if.if_empty_n), 32'd0);
    chk("s6_full_n",  32'(fifo_if.if_full_n),  32'd1);
    chk("s6_errs",    32'({err_ovf, err_udf}), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    push1(8'hD0);
    chk("s6_count_after", 32'(count),            32'd1);
    chk("s6_head_after",  32'(fifo_if.if_dout),  32'hD0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
